seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load  input  1  single-cycle request to update the displayed value.
REQ-005 SHALL have port data_in  input  16  four hex nibbles, digit 0 = data_in[3:0] ... digit 3 = data_in[15:12].
REQ-006 SHALL have port blank_lz  input  1  leading-zero suppression flag, captured with load.
REQ-007 SHALL have port din  output  4  nibble for the active digit, fed to the 7-seg decoder.
REQ-008 SHALL have port ch  output  2  active digit index, fed to the 7-seg decoder's anode select.
REQ-009 SHALL have port pending  output  1  high while a loaded value waits for the frame boundary.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at every frame boundary.

Function
REQ-011 SHALL hold a divider counter cnt counting 0..REFRESH_DIV-1 and wrapping to 0; tick = (cnt == REFRESH_DIV-1).
REQ-012 SHALL increment ch on the cycle after each tick, wrapping 3 -> 0; ch SHALL not change otherwise.
REQ-013 SHALL define frame boundary as a tick while ch == 3.
REQ-014 SHALL capture data_in and blank_lz into a pending register and set pending when load = 1; a later load before the boundary SHALL overwrite, last value wins.
REQ-015 SHALL, at a frame boundary with pending = 1, copy the pending value and flag into the shown registers and clear pending, taking effect with ch = 0.
REQ-016 SHALL, on load coinciding with a frame boundary, commit the previously pending value (if any) and leave the new value pending (pending = 1) for the next boundary.
REQ-017 SHALL assert frame_done for exactly one cycle on the cycle after every frame boundary, regardless of pending.
REQ-018 SHALL drive din = shown[4*ch+3 : 4*ch] when no blanking applies.
REQ-019 SHALL, when shown blank flag = 1, drive din = 4'hF (decoder blank code) for digit k in 1..3 if nibbles k..3 of shown are all zero; digit 0 SHALL never be blanked.
REQ-020 SHALL derive din, ch, pending and frame_done from registers only; no combinational path from any input to any output.
REQ-021 SHALL never present a torn frame: shown value changes only at a frame boundary.

Reset
REQ-022 SHALL, while reset = 1 at a clock edge, set cnt = 0, ch = 0, shown = 16'h0000, shown blank flag = 0, pending register = 0, pending = 0, frame_done = 0; hence din = 4'h0.
REQ-023 SHALL give reset priority over load and tick in the same cycle; a pending value SHALL be discarded by reset mid-frame.
REQ-024 SHALL resume scanning at ch = 0, cnt = 0 on the first edge after reset deasserts.

Verification (REFRESH_DIV = 4)
REQ-025 SHALL cover: reset, then free run -> ch sequence 0,1,2,3,0 each held 4 cycles; din = 0; frame_done pulses every 16 cycles.
REQ-026 SHALL cover: load data_in = 16'h1A2B mid-frame (ch = 1) -> pending = 1; shown unchanged until boundary; next frame din = B,2,A,1 for ch 0..3; pending = 0 after boundary.
REQ-027 SHALL cover: load 16'h0042 with blank_lz = 1 -> din = 2,4,F,F; load 16'h0000 with blank_lz = 1 -> din = 0,F,F,F.
REQ-028 SHALL cover: loads 16'h1111 then 16'h2222 in same frame -> next frame shows 2222 only; load 16'h3333 on a boundary cycle -> previous pending committed, 3333 shown one frame later.
REQ-029 SHALL cover: load 16'hFFFF then reset before boundary -> after reset din = 0, pending = 0, 16'hFFFF never displayed.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Bus between a display-value producer and the seg_scan_ctrl digit scanner.
// The master loads new values; the slave scans them out one digit slot at a time.
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] data_in;
  logic        blank_lz;
  logic [3:0]  din;
  logic [1:0]  ch;
  logic        pending;
  logic        frame_done;

  modport master (
    output load, data_in, blank_lz,
    input  din, ch, pending, frame_done
  );

  modport slave (
    input  load, data_in, blank_lz,
    output din, ch, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a frame-synchronous,
// double-buffered display value and optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic          clk,
  input  logic          reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ch_q, ch_d;
  logic [15:0]      shown_q, shown_d;
  logic             shownBlank_q, shownBlank_d;
  logic [15:0]      pendData_q, pendData_d;
  logic             pendBlank_q, pendBlank_d;
  logic             pending_q, pending_d;
  logic             frameDone_q, frameDone_d;

  logic             tick;
  logic             boundary;
  logic [3:0]       zeroFrom;
  logic [3:0]       nibble;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      ch_q         <= 2'd0;
      shown_q      <= 16'h0000;
      shownBlank_q <= 1'b0;
      pendData_q   <= 16'h0000;
      pendBlank_q  <= 1'b0;
      pending_q    <= 1'b0;
      frameDone_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      shown_q      <= shown_d;
      shownBlank_q <= shownBlank_d;
      pendData_q   <= pendData_d;
      pendBlank_q  <= pendBlank_d;
      pending_q    <= pending_d;
      frameDone_q  <= frameDone_d;
    end
  end

  // A boundary commits the old pending value before a same-cycle load replaces it.
  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    boundary     = tick && (ch_q == 2'd3);
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    ch_d         = ch_q;
    shown_d      = shown_q;
    shownBlank_d = shownBlank_q;
    pendData_d   = pendData_q;
    pendBlank_d  = pendBlank_q;
    pending_d    = pending_q;
    frameDone_d  = boundary;

    if (tick) begin
      ch_d = ch_q + 2'd1;
    end

    if (boundary && pending_q) begin
      shown_d      = pendData_q;
      shownBlank_d = pendBlank_q;
    end

    if (bus.load) begin
      pendData_d  = bus.data_in;
      pendBlank_d = bus.blank_lz;
      pending_d   = 1'b1;
    end else if (boundary) begin
      pending_d = 1'b0;
    end
  end

  // zeroFrom[k]: nibbles k..3 of the shown value are all zero; digit 0 is never blanked.
  always_comb begin
    zeroFrom[3] = (shown_q[15:12] == 4'h0);
    zeroFrom[2] = zeroFrom[3] && (shown_q[11:8] == 4'h0);
    zeroFrom[1] = zeroFrom[2] && (shown_q[7:4] == 4'h0);
    zeroFrom[0] = 1'b0;
    nibble      = shown_q[{ch_q, 2'b00} +: 4];
  end

  assign bus.din        = (shownBlank_q && zeroFrom[ch_q]) ? 4'hF : nibble;
  assign bus.ch         = ch_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frameDone_q;

endmodule
